// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO bus arbiter: FSM states, master IDs,
// DATA segment and GPIO register offsets.
package gpio_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_t;

    localparam logic [15:0] DATA_SEG      = 16'h1001;
    localparam logic [15:0] GPIO_LEDS_OFS = 16'h0024;
    localparam logic [15:0] GPIO_SW_OFS   = 16'h0028;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select: a tie goes to the master that did not
// own the previous transaction.
module rr_arbiter2
    import gpio_bus_pkg::*;
(
    input  logic    m0_req,
    input  logic    m1_req,
    input  master_t last_owner,
    output logic    valid,
    output master_t winner
);

    always_comb begin
        valid  = m0_req | m1_req;
        winner = M0;
        if (m0_req && m1_req) begin
            if (last_owner == M0) begin
                winner = M1;
            end
        end else if (m1_req) begin
            winner = M1;
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Shares the GPIO peripheral port between M0 (core) and M1 (debug/loader) with
// an IDLE -> ACCESS -> RESP cycle. Define ARB_ERR_EN to reject off-segment addresses.
module gpio_bus_arbiter
    import gpio_bus_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [15:0] PERIPH_BASE = DATA_SEG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              periph_sel,
    output logic              periph_we,
    output logic [ADDR_W-1:0] periph_adr,
    output logic [DATA_W-1:0] periph_wdata,
    input  logic [DATA_W-1:0] periph_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    master_t           owner, last_owner;
    logic              arb_valid;
    master_t           arb_winner;
    logic              lat_we, lat_err;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic [DATA_W-1:0] resp_data;

    rr_arbiter2 u_arb (
        .m0_req     (m0_req),
        .m1_req     (m1_req),
        .last_owner (last_owner),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign sel_addr  = (arb_winner == M1) ? m1_addr  : m0_addr;
    assign sel_we    = (arb_winner == M1) ? m1_we    : m0_we;
    assign sel_wdata = (arb_winner == M1) ? m1_wdata : m0_wdata;

`ifdef ARB_ERR_EN
    assign sel_err = (sel_addr[ADDR_W-1 -: 16] != PERIPH_BASE);
`else
    logic unused_base;
    assign unused_base = ^PERIPH_BASE;
    assign sel_err     = 1'b0;
`endif

    // Writes and rejected accesses return zero, so the read mux stays out of RESP.
    assign resp_data = (lat_we || lat_err) ? '0 : periph_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_err       = 1'b0;
        m1_err       = 1'b0;
        periph_sel   = 1'b0;
        periph_we    = 1'b0;
        periph_adr   = '0;
        periph_wdata = '0;
        busy         = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (arb_valid) begin
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_nxt    = S_RESP;
                m0_gnt       = (owner == M0);
                m1_gnt       = (owner == M1);
                periph_sel   = !lat_err;
                periph_we    = lat_we && !lat_err;
                periph_adr   = lat_addr;
                periph_wdata = lat_wdata;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                m0_rvalid = (owner == M0);
                m1_rvalid = (owner == M1);
                m0_err    = (owner == M0) && lat_err;
                m1_err    = (owner == M1) && lat_err;
            end
            default: begin
                state_nxt = S_IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= M0;
            last_owner <= M1;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == S_IDLE && arb_valid) begin
                owner     <= arb_winner;
                lat_we    <= sel_we;
                lat_err   <= sel_err;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (state == S_ACCESS) begin
                last_owner <= owner;
                if (owner == M0) begin
                    m0_rdata <= resp_data;
                end else begin
                    m1_rdata <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed table, corner sequences,
// and randomized traffic against a transaction-level timing/fairness model.
module tb_gpio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        periph_sel, periph_we, busy;
    logic [31:0] periph_adr, periph_wdata, periph_rdata;

    logic        use_fn;
    logic [31:0] rd_fixed;

    int total = 0;
    int bad   = 0;

    gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PERIPH_BASE(16'h1001)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .periph_sel(periph_sel), .periph_we(periph_we), .periph_adr(periph_adr),
        .periph_wdata(periph_wdata), .periph_rdata(periph_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Peripheral stand-in: either a fixed value or an address-derived pattern.
    function automatic logic [31:0] pfn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    assign periph_rdata = use_fn ? pfn(periph_adr) : rd_fixed;

    function automatic logic addr_bad(input logic [31:0] a);
`ifdef ARB_ERR_EN
        return a[31:16] != 16'h1001;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        mst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prd;
        logic        exp_sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[6];

    logic        req_a[2], we_a[2];
    logic [31:0] addr_a[2], wdata_a[2];

    initial begin
        logic [1:0]  gorder[$];
        logic [31:0] rd_act;
        logic        errb;

        tbl[0] = '{1'b0, 1'b1, 32'h1001_0024, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h1001_0028, 32'h0,         32'h0000_003C, 1'b1, 1'b0, 32'h3C};
        tbl[2] = '{1'b0, 1'b0, 32'h1001_0028, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678};
        tbl[3] = '{1'b1, 1'b1, 32'h1001_0024, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0};
`ifdef ARB_ERR_EN
        tbl[4] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
`else
        tbl[4] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D};
`endif
        tbl[5] = '{1'b1, 1'b0, 32'h1001_FFFC, 32'h0,         32'h0000_0001, 1'b1, 1'b0, 32'h1};

        use_fn = 1'b0;
        rd_fixed = '0;

        // Reset then idle
        do_reset;
        for (int i = 0; i < 10; i++) begin
            chk("idle_outputs",
                {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, periph_sel, periph_we, busy,
                 periph_adr, periph_wdata}, '0);
            tick;
        end
        chk("idle_rdata", {m0_rdata, m1_rdata}, '0);

        // Directed single transactions
        for (int i = 0; i < 6; i++) begin
            rd_fixed = tbl[i].prd;
            if (tbl[i].mst) begin
                m1_req = 1'b1; m1_we = tbl[i].we; m1_addr = tbl[i].addr; m1_wdata = tbl[i].wdata;
            end else begin
                m0_req = 1'b1; m0_we = tbl[i].we; m0_addr = tbl[i].addr; m0_wdata = tbl[i].wdata;
            end
            tick;
            chk("vec_gnt", {m1_gnt, m0_gnt, busy}, {tbl[i].mst, !tbl[i].mst, 1'b1});
            chk("vec_sel", periph_sel, tbl[i].exp_sel);
            if (tbl[i].exp_sel)
                chk("vec_periph", {periph_we, periph_adr, periph_wdata},
                    {tbl[i].we, tbl[i].addr, tbl[i].wdata});
            m0_req = 1'b0; m1_req = 1'b0;
            tick;
            rd_act = tbl[i].mst ? m1_rdata : m0_rdata;
            errb   = tbl[i].mst ? m1_err : m0_err;
            chk("vec_rvalid", {m1_rvalid, m0_rvalid, m1_gnt, m0_gnt, periph_sel},
                {tbl[i].mst, !tbl[i].mst, 3'b000});
            chk("vec_rdata", {errb, rd_act}, {tbl[i].exp_err, tbl[i].exp_rdata});
            tick;
            rd_act = tbl[i].mst ? m1_rdata : m0_rdata;
            chk("vec_hold", {busy, m1_rvalid, m0_rvalid, rd_act}, {3'b000, tbl[i].exp_rdata});
        end

        // Contention from reset: grants must alternate starting with M0
        do_reset;
        m0_req = 1'b1; m0_addr = 32'h1001_0024; m0_we = 1'b1; m0_wdata = 32'h11;
        m1_req = 1'b1; m1_addr = 32'h1001_0028; m1_we = 1'b0;
        for (int c = 0; c < 30 && gorder.size() < 4; c++) begin
            tick;
            chk("excl", {m0_gnt & m1_gnt, m0_rvalid & m1_rvalid}, 2'b00);
            if (m0_gnt || m1_gnt) gorder.push_back({m1_gnt, m0_gnt});
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("cont_count", gorder.size(), 4);
        for (int k = 0; k < gorder.size(); k++)
            chk("cont_order", gorder[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        tick; tick;
        chk("cont_end", {busy, m0_rvalid, m1_rvalid}, 3'b000);

        // Reset during ACCESS aborts the transaction
        do_reset;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0028;
        tick;
        chk("abort_access", {periph_sel, m0_gnt, busy}, 3'b111);
        m0_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_async", {periph_sel, m0_gnt, busy, periph_adr}, '0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("abort_quiet", {m0_rvalid, m1_rvalid, busy, m0_gnt}, 4'b0000);
        end

        // Randomized traffic against a transaction-level model
        do_reset;
        use_fn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0; we_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
        end
        begin
            int   e;
            int   idle_after;
            int   rv_edge;
            logic lastw, win, rv_m, rv_err, ok;
            logic [31:0] rv_data;
            logic [1:0]  smp, exp_g, exp_rv;
            idle_after = -1;
            rv_edge = -10;
            lastw = 1'b1;
            rv_m = 1'b0; rv_err = 1'b0; rv_data = '0; win = 1'b0;
            for (e = 0; e < 2000; e++) begin
                tick;
                smp   = {m1_req, m0_req};
                exp_g = 2'b00;
                if (e > idle_after && smp != 2'b00) begin
                    if (smp == 2'b11) win = !lastw;
                    else              win = smp[1];
                    lastw      = win;
                    exp_g      = win ? 2'b10 : 2'b01;
                    idle_after = e + 2;
                    rv_edge    = e + 1;
                    rv_m       = win;
                    ok         = !addr_bad(addr_a[win]);
                    rv_err     = !ok;
                    rv_data    = (we_a[win] || !ok) ? 32'h0 : pfn(addr_a[win]);
                end
                exp_rv = (e == rv_edge) ? (rv_m ? 2'b10 : 2'b01) : 2'b00;
                chk("rnd_ctl", {m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, busy},
                    {exp_g, exp_rv, (e < idle_after)});
                if (exp_g != 2'b00) begin
                    chk("rnd_sel", periph_sel, !rv_err);
                    if (!rv_err)
                        chk("rnd_periph", {periph_we, periph_adr, periph_wdata},
                            {we_a[win], addr_a[win], wdata_a[win]});
                    req_a[win] = 1'b0;
                end else if (exp_rv == 2'b00) begin
                    chk("rnd_quiet", {periph_sel, periph_adr}, '0);
                end
                if (exp_rv != 2'b00) begin
                    rd_act = rv_m ? m1_rdata : m0_rdata;
                    errb   = rv_m ? m1_err : m0_err;
                    chk("rnd_rdata", {errb, rd_act}, {rv_err, rv_data});
                end
                for (int k = 0; k < 2; k++) begin
                    if (!req_a[k] && $urandom_range(0, 3) == 0) begin
                        req_a[k]   = 1'b1;
                        we_a[k]    = 1'($urandom_range(0, 1));
                        addr_a[k]  = ($urandom_range(0, 7) == 0) ? $urandom()
                                   : {16'h1001, 16'($urandom()) & 16'hFFFC};
                        wdata_a[k] = $urandom();
                    end
                end
                m0_req = req_a[0]; m0_we = we_a[0]; m0_addr = addr_a[0]; m0_wdata = wdata_a[0];
                m1_req = req_a[1]; m1_we = we_a[1]; m1_addr = addr_a[1]; m1_wdata = wdata_a[1];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
